mm_radix16_pipe: RTL and testbench

Pipelined word-serial processing element for Montgomery modular multiplication, using a 16-bit digit (radix 2^16).
- Each enabled cycle it accepts one 16-bit word of B, M and the partial result D, and returns one result word D_o three enabled cycles later.
- On the first word of a row (`init`) it derives and latches the Montgomery quotient digit q.
- It carries the inter-word carry internally.
- It sits inside the modexp datapath; a controller sequences words and rows.

---
 rtl/mm_pkg.sv | 12 +
 rtl/mm_mul16.sv | 15 +
 rtl/mm_radix16_pipe.sv | 102 ++++++++++
 tb/tb_mm_radix16_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared widths for the radix-2^16 Montgomery multiplication datapath.
package mm_pkg;

    localparam int WORD_W      = 16;
    localparam int CARRY_W     = 18;
    localparam int MM_PIPE_LAT = 3;

    // Widths of the partial sum S = A*B + D and of T = S + q*M + Cin.
    localparam int SUM_W = 2 * WORD_W + 1;
    localparam int T_W   = WORD_W + CARRY_W;

endpackage : mm_pkg

// File: rtl/mm_mul16.sv
// Unsigned 16x16 multiplier, kept as its own module so each product maps onto a DSP block.
module mm_mul16
    import mm_pkg::*;
#(
    parameter int OUT_W = 2 * WORD_W
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic [OUT_W-1:0]  o_p
);

    // A narrower OUT_W gives the product modulo 2^OUT_W directly.
    assign o_p = OUT_W'(i_a) * OUT_W'(i_b);

endmodule : mm_mul16

// File: rtl/mm_radix16_pipe.sv
// Word-serial Montgomery processing element: three-stage pipeline computing
// D_o = (A*B + D + q*M + carry) mod 2^16, with q derived and latched on init words.
module mm_radix16_pipe
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              init,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic [WORD_W-1:0] M,
    input  logic [WORD_W-1:0] M0,
    input  logic [WORD_W-1:0] D,
    output logic [WORD_W-1:0] D_o
);

    logic [2*WORD_W-1:0] w_ab;
    logic [WORD_W-1:0]   w_qNext;
    logic [2*WORD_W-1:0] w_qm;
    logic [CARRY_W-1:0]  w_cin;
    logic [T_W-1:0]      w_t;

    logic [SUM_W-1:0]    r_s1;
    logic [WORD_W-1:0]   r_m1;
    logic [WORD_W-1:0]   r_m0;
    logic                r_init1;

    logic [SUM_W-1:0]    r_s2;
    logic [WORD_W-1:0]   r_m2;
    logic                r_init2;
    logic [WORD_W-1:0]   r_q;

    logic [CARRY_W-1:0]  r_c;
    logic [WORD_W-1:0]   r_do;

    mm_mul16 u_mulAB (
        .i_a (A),
        .i_b (B),
        .o_p (w_ab)
    );

    mm_mul16 #(.OUT_W(WORD_W)) u_mulQ (
        .i_a (r_s1[WORD_W-1:0]),
        .i_b (r_m0),
        .o_p (w_qNext)
    );

    mm_mul16 u_mulQM (
        .i_a (r_q),
        .i_b (r_m2),
        .o_p (w_qm)
    );

    // An init word in stage 3 starts a fresh row, so it ignores the stored carry.
    assign w_cin = r_init2 ? '0 : r_c;
    assign w_t   = T_W'(r_s2) + T_W'(w_qm) + T_W'(w_cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_m1    <= '0;
            r_m0    <= '0;
            r_init1 <= 1'b0;
        end else if (ce) begin
            r_s1    <= SUM_W'(w_ab) + SUM_W'(D);
            r_m1    <= M;
            r_m0    <= M0;
            r_init1 <= init;
        end
    end

    // q is loaded one edge before the init word reaches stage 3, so it sees the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2    <= '0;
            r_m2    <= '0;
            r_init2 <= 1'b0;
            r_q     <= '0;
        end else if (ce) begin
            r_s2    <= r_s1;
            r_m2    <= r_m1;
            r_init2 <= r_init1;
            if (r_init1) begin
                r_q <= w_qNext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c  <= '0;
            r_do <= '0;
        end else if (ce) begin
            r_c  <= w_t[T_W-1:WORD_W];
            r_do <= w_t[WORD_W-1:0];
        end
    end

    assign D_o = r_do;

endmodule : mm_radix16_pipe

// File: tb/tb_mm_radix16_pipe.sv
// Directed self-checking bench for mm_radix16_pipe: hand-computed vectors plus a
// word-level reference model of the Montgomery row recurrence.
module tb_mm_radix16_pipe;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        init;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] M;
    logic [15:0] M0;
    logic [15:0] D;
    logic [15:0] D_o;

    int testCount;
    int failCount;

    logic [15:0] modelQ;
    logic [63:0] modelC;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [15:0] exp2;

    mm_radix16_pipe dut (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .init (init),
        .A    (A),
        .B    (B),
        .M    (M),
        .M0   (M0),
        .D    (D),
        .D_o  (D_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one word of the row recurrence, in sample order.
    function automatic logic [15:0] modelWord(input logic iInit, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] m,
                                              input logic [15:0] m0, input logic [15:0] d);
        logic [63:0] s;
        logic [63:0] t;
        logic [63:0] cin;
        s = 64'(a) * 64'(b) + 64'(d);
        if (iInit) begin
            modelQ = 16'((64'(s[15:0]) * 64'(m0)) & 64'hFFFF);
            cin    = 64'd0;
        end else begin
            cin = modelC;
        end
        t      = s + 64'(modelQ) * 64'(m) + cin;
        modelC = t >> 16;
        return t[15:0];
    endfunction

    task automatic modelReset();
        modelQ = '0;
        modelC = '0;
        exp0   = '0;
        exp1   = '0;
        exp2   = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        testCount++;
        assert (D_o === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: D_o=%0h expected %0h", tag, D_o, expected);
        end
    endtask

    task automatic applyStimulus(input logic iInit, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] m, input logic [15:0] m0,
                                 input logic [15:0] d);
        init = iInit;
        A    = a;
        B    = b;
        M    = m;
        M0   = m0;
        D    = d;
        @(posedge clk);
        #1;
        if (ce && !rst) begin
            exp2 = exp1;
            exp1 = exp0;
            exp0 = modelWord(iInit, a, b, m, m0, d);
        end
        checkOutput("pipe", exp2);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        modelReset();
        rst  = 1'b1;
        ce   = 1'b1;
        init = 1'b0;
        A = '0; B = '0; M = '0; M0 = '0; D = '0;

        // Reset held with random inputs: output must stay 0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom));
        end
        rst = 1'b0;

        // Init word with arbitrary M0: q=160, every word gives 1472.
        applyStimulus(1'b1, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        checkOutput("drain0", 16'd0);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        checkOutput("drain1", 16'd0);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        checkOutput("arbInit", 16'd1472);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        checkOutput("arbWord1", 16'd1472);

        // Proper inverse: q=14560, init word gives 0 with carry 2, then 2.
        applyStimulus(1'b1, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("arbWord2", 16'd1472);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("monInit", 16'd0);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("monWord1", 16'd2);

        // Back-to-back init words: second one clears carry 2 and restores q=160.
        applyStimulus(1'b1, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("monWord2", 16'd2);
        applyStimulus(1'b1, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd5, 16'd7);
        checkOutput("b2bInitA", 16'd0);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF);
        checkOutput("b2bInitB", 16'd1472);

        // Maximum operands, q=0: outputs 0 then FFFF with carry FFFF.
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF);
        checkOutput("b2bWord", 16'd1472);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF);
        end

        // D=FFFE gives q=FFFF and a 17-bit carry (1FFFD, then 1FFFE).
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFE);
        checkOutput("maxWord3", 16'hFFFF);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFE);
        checkOutput("maxWord4", 16'hFFFF);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFE);
        checkOutput("wideInit", 16'h0000);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFE);
        checkOutput("wideWord1", 16'hFFFD);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFE);
        checkOutput("wideWord2", 16'hFFFE);

        // Stall mid-row; a stray init during the stall must be ignored.
        applyStimulus(1'b1, 16'd3, 16'h1234, 16'hF00D, 16'h0101, 16'h0042);
        applyStimulus(1'b0, 16'd3, 16'h5678, 16'hBEEF, 16'h0101, 16'h1111);
        applyStimulus(1'b0, 16'd3, 16'h9ABC, 16'hCAFE, 16'h0101, 16'h2222);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF, 16'h7777);
        end
        ce = 1'b1;
        applyStimulus(1'b0, 16'd3, 16'hDEF0, 16'h1357, 16'h0101, 16'h3333);
        applyStimulus(1'b0, 16'd3, 16'h0F0F, 16'h2468, 16'h0101, 16'h4444);
        applyStimulus(1'b0, 16'd3, 16'hF0F0, 16'hFFFF, 16'h0101, 16'h5555);
        applyStimulus(1'b0, 16'd3, 16'h0001, 16'h0001, 16'h0101, 16'h0000);

        // Asynchronous reset between edges clears D_o immediately.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstAsync", 16'd0);
        modelReset();
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        rst = 1'b0;

        // New row after reset reproduces the proper-inverse results.
        applyStimulus(1'b1, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("rstMonInit", 16'd0);
        applyStimulus(1'b0, 16'd5, 16'd5, 16'd9, 16'd29127, 16'd7);
        checkOutput("rstMonWord1", 16'd2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_mm_radix16_pipe
